// File: rtl/l2_tlb_responder.sv
// Second-level TLB: fully-associative cache of leaf PTEs tagged by {asid, vpn}.
// Serves one L1 TLB miss at a time and forwards its own misses to the page table walker.
`timescale 1ns/1ps
module l2_tlb_responder #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_l1tlb_req_ready,
  input  logic        io_l1tlb_req_valid,
  input  logic [26:0] io_l1tlb_req_bits_addr,
  input  logic [1:0]  io_l1tlb_req_bits_prv,
  input  logic        io_l1tlb_req_bits_pum,
  input  logic        io_l1tlb_req_bits_mxr,
  input  logic        io_l1tlb_req_bits_store,
  input  logic        io_l1tlb_req_bits_fetch,
  output logic        io_l1tlb_resp_valid,
  output logic [37:0] io_l1tlb_resp_bits_pte_ppn,
  output logic        io_l1tlb_resp_bits_pte_d,
  output logic        io_l1tlb_resp_bits_pte_a,
  output logic        io_l1tlb_resp_bits_pte_g,
  output logic        io_l1tlb_resp_bits_pte_u,
  output logic        io_l1tlb_resp_bits_pte_x,
  output logic        io_l1tlb_resp_bits_pte_w,
  output logic        io_l1tlb_resp_bits_pte_r,
  output logic        io_l1tlb_resp_bits_pte_v,
  output logic [15:0] io_l1tlb_resp_bits_pte_reserved_for_hardware,
  output logic [1:0]  io_l1tlb_resp_bits_pte_reserved_for_software,
  input  logic [6:0]  io_ptw_ptbr_asid,
  input  logic        io_ptw_invalidate,
  output logic        io_ptw_req_valid,
  input  logic        io_ptw_req_ready,
  output logic [26:0] io_ptw_req_bits_addr,
  output logic [1:0]  io_ptw_req_bits_prv,
  output logic        io_ptw_req_bits_pum,
  output logic        io_ptw_req_bits_mxr,
  output logic        io_ptw_req_bits_store,
  output logic        io_ptw_req_bits_fetch,
  input  logic        io_ptw_resp_valid,
  input  logic [37:0] io_ptw_resp_bits_pte_ppn,
  input  logic        io_ptw_resp_bits_pte_d,
  input  logic        io_ptw_resp_bits_pte_a,
  input  logic        io_ptw_resp_bits_pte_g,
  input  logic        io_ptw_resp_bits_pte_u,
  input  logic        io_ptw_resp_bits_pte_x,
  input  logic        io_ptw_resp_bits_pte_w,
  input  logic        io_ptw_resp_bits_pte_r,
  input  logic        io_ptw_resp_bits_pte_v,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid and its payload hold steady until that edge, and ready never depends on valid.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_PTW_REQ  = 3'd2,
    S_PTW_WAIT = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [26:0]        r_addr_q, r_addr_d;
  logic [1:0]         r_prv_q, r_prv_d;
  logic               r_pum_q, r_pum_d;
  logic               r_mxr_q, r_mxr_d;
  logic               r_store_q, r_store_d;
  logic               r_fetch_q, r_fetch_d;
  logic [6:0]         r_asid_q, r_asid_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [26:0]        tag_vpn_q [ENTRIES];
  logic [26:0]        tag_vpn_d [ENTRIES];
  logic [6:0]         tag_asid_q [ENTRIES];
  logic [6:0]         tag_asid_d [ENTRIES];
  logic [37:0]        ent_ppn_q [ENTRIES];
  logic [37:0]        ent_ppn_d [ENTRIES];
  // Flag byte order is {d,a,g,u,x,w,r,v}; bit 5 doubles as the global tag bit.
  logic [7:0]         ent_flags_q [ENTRIES];
  logic [7:0]         ent_flags_d [ENTRIES];
  logic [37:0]        resp_ppn_q, resp_ppn_d;
  logic [7:0]         resp_flags_q, resp_flags_d;
  logic [IDX_W-1:0]   repl_ptr_q, repl_ptr_d;
  logic               inv_pending_q, inv_pending_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   fill_idx;
  logic               fill_ok;
  logic [7:0]         ptw_flags;

  assign ptw_flags = {io_ptw_resp_bits_pte_d, io_ptw_resp_bits_pte_a,
                      io_ptw_resp_bits_pte_g, io_ptw_resp_bits_pte_u,
                      io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_w,
                      io_ptw_resp_bits_pte_r, io_ptw_resp_bits_pte_v};

  // Descending scans so the lowest matching / free index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_vpn_q[i] == r_addr_q &&
          (ent_flags_q[i][5] || tag_asid_q[i] == r_asid_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    r_addr_d      = r_addr_q;
    r_prv_d       = r_prv_q;
    r_pum_d       = r_pum_q;
    r_mxr_d       = r_mxr_q;
    r_store_d     = r_store_q;
    r_fetch_d     = r_fetch_q;
    r_asid_d      = r_asid_q;
    valid_d       = valid_q;
    tag_vpn_d     = tag_vpn_q;
    tag_asid_d    = tag_asid_q;
    ent_ppn_d     = ent_ppn_q;
    ent_flags_d   = ent_flags_q;
    resp_ppn_d    = resp_ppn_q;
    resp_flags_d  = resp_flags_q;
    repl_ptr_d    = repl_ptr_q;
    inv_pending_d = inv_pending_q;
    fill_ok  = io_ptw_resp_bits_pte_v && (io_ptw_resp_bits_pte_r || io_ptw_resp_bits_pte_x) &&
               !inv_pending_q && !io_ptw_invalidate;
    fill_idx = has_free ? free_idx : repl_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (io_l1tlb_req_valid) begin
          r_addr_d  = io_l1tlb_req_bits_addr;
          r_prv_d   = io_l1tlb_req_bits_prv;
          r_pum_d   = io_l1tlb_req_bits_pum;
          r_mxr_d   = io_l1tlb_req_bits_mxr;
          r_store_d = io_l1tlb_req_bits_store;
          r_fetch_d = io_l1tlb_req_bits_fetch;
          r_asid_d  = io_ptw_ptbr_asid;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit && !io_ptw_invalidate) begin
          resp_ppn_d   = ent_ppn_q[hit_idx];
          resp_flags_d = ent_flags_q[hit_idx];
          state_d      = S_RESP;
        end else begin
          state_d = S_PTW_REQ;
        end
      end
      S_PTW_REQ: begin
        if (io_ptw_req_ready) state_d = S_PTW_WAIT;
      end
      S_PTW_WAIT: begin
        if (io_ptw_resp_valid) begin
          resp_ppn_d   = io_ptw_resp_bits_pte_ppn;
          resp_flags_d = ptw_flags;
          state_d      = S_RESP;
          if (fill_ok) begin
            valid_d[fill_idx]     = 1'b1;
            tag_vpn_d[fill_idx]   = r_addr_q;
            tag_asid_d[fill_idx]  = r_asid_q;
            ent_ppn_d[fill_idx]   = io_ptw_resp_bits_pte_ppn;
            ent_flags_d[fill_idx] = ptw_flags;
            if (!has_free) repl_ptr_d = repl_ptr_q + IDX_W'(1);
          end
        end
      end
      S_RESP: begin
        state_d       = S_IDLE;
        inv_pending_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over any fill computed above; a walk in flight is marked stale.
    if (io_ptw_invalidate) begin
      valid_d = '0;
      if (state_q == S_PTW_REQ || state_q == S_PTW_WAIT) inv_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      r_addr_q      <= '0;
      r_prv_q       <= '0;
      r_pum_q       <= 1'b0;
      r_mxr_q       <= 1'b0;
      r_store_q     <= 1'b0;
      r_fetch_q     <= 1'b0;
      r_asid_q      <= '0;
      valid_q       <= '0;
      resp_ppn_q    <= '0;
      resp_flags_q  <= '0;
      repl_ptr_q    <= '0;
      inv_pending_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_vpn_q[i]   <= '0;
        tag_asid_q[i]  <= '0;
        ent_ppn_q[i]   <= '0;
        ent_flags_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      r_addr_q      <= r_addr_d;
      r_prv_q       <= r_prv_d;
      r_pum_q       <= r_pum_d;
      r_mxr_q       <= r_mxr_d;
      r_store_q     <= r_store_d;
      r_fetch_q     <= r_fetch_d;
      r_asid_q      <= r_asid_d;
      valid_q       <= valid_d;
      resp_ppn_q    <= resp_ppn_d;
      resp_flags_q  <= resp_flags_d;
      repl_ptr_q    <= repl_ptr_d;
      inv_pending_q <= inv_pending_d;
      tag_vpn_q     <= tag_vpn_d;
      tag_asid_q    <= tag_asid_d;
      ent_ppn_q     <= ent_ppn_d;
      ent_flags_q   <= ent_flags_d;
    end
  end

  assign io_l1tlb_req_ready  = (state_q == S_IDLE);
  assign io_l1tlb_resp_valid = (state_q == S_RESP);
  assign io_l1tlb_resp_bits_pte_ppn = resp_ppn_q;
  assign io_l1tlb_resp_bits_pte_d   = resp_flags_q[7];
  assign io_l1tlb_resp_bits_pte_a   = resp_flags_q[6];
  assign io_l1tlb_resp_bits_pte_g   = resp_flags_q[5];
  assign io_l1tlb_resp_bits_pte_u   = resp_flags_q[4];
  assign io_l1tlb_resp_bits_pte_x   = resp_flags_q[3];
  assign io_l1tlb_resp_bits_pte_w   = resp_flags_q[2];
  assign io_l1tlb_resp_bits_pte_r   = resp_flags_q[1];
  assign io_l1tlb_resp_bits_pte_v   = resp_flags_q[0];
  assign io_l1tlb_resp_bits_pte_reserved_for_hardware = '0;
  assign io_l1tlb_resp_bits_pte_reserved_for_software = '0;
  assign io_ptw_req_valid      = (state_q == S_PTW_REQ);
  assign io_ptw_req_bits_addr  = r_addr_q;
  assign io_ptw_req_bits_prv   = r_prv_q;
  assign io_ptw_req_bits_pum   = r_pum_q;
  assign io_ptw_req_bits_mxr   = r_mxr_q;
  assign io_ptw_req_bits_store = r_store_q;
  assign io_ptw_req_bits_fetch = r_fetch_q;
  assign dbg_state             = state_q;

endmodule
